// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the interconnect and its slaves.
package axi4l_pkg;

  localparam int DATA_SIZE = 32;
  localparam int STRB_W    = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi4l_wstrb_merge.sv
// Byte-strobe merge: each enabled byte lane takes the new word, others keep the old.
module axi4l_wstrb_merge #(
  parameter int W  = 32,
  parameter int SW = W / 8
) (
  input  logic [W-1:0]  old_i,
  input  logic [W-1:0]  new_i,
  input  logic [SW-1:0] strb_i,
  output logic [W-1:0]  merged_o
);

  // Per-lane select between old and new byte
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < SW; b++) begin
      if (strb_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4l_regfile_slave.sv
// AXI4-Lite register-file slave: NREGS x 32-bit R/W registers with byte strobes,
// decoupled AW/W hold registers, single outstanding read, flat register export.
module axi4l_regfile_slave
  import axi4l_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int NREGS     = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [ADDR_SIZE-1:0]       awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_SIZE-1:0]       wdata,
  input  logic [DATA_SIZE/8-1:0]     wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_SIZE-1:0]       araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_SIZE-1:0]       rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NREGS*DATA_SIZE-1:0] regs_out
);

  localparam int SW = DATA_SIZE / 8;
  localparam int IW = ADDR_SIZE - 2;

  // Architectural state
  logic [NREGS-1:0][DATA_SIZE-1:0] regs_q, regs_d;
  logic                 aw_held_q, aw_held_d;
  logic [ADDR_SIZE-1:0] aw_addr_q, aw_addr_d;
  logic                 w_held_q, w_held_d;
  logic [DATA_SIZE-1:0] w_data_q, w_data_d;
  logic [SW-1:0]        w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  resp_t                bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  resp_t                rresp_q, rresp_d;

  // Write-path decode
  logic                 aw_hs, w_hs, commit;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [SW-1:0]        wr_strb;
  logic [IW-1:0]        wr_idx;
  logic                 wr_inrange;
  logic [NREGS-1:0]     wen;
  logic [NREGS-1:0][DATA_SIZE-1:0] merged;

  // Read-path decode
  logic                 ar_hs;
  logic [IW-1:0]        rd_idx;
  logic                 rd_inrange;
  logic [DATA_SIZE-1:0] rd_word;

  // Address bits [1:0] carry no meaning for word registers
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

  assign awready  = !aw_held_q;
  assign wready   = !w_held_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = !rvalid_q || rready;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign regs_out = regs_q;

  // Write channel: pick held or live beat, commit when both present and B slot free
  always_comb begin
    aw_hs      = awvalid && !aw_held_q;
    w_hs       = wvalid && !w_held_q;
    commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (!bvalid_q || bready);
    wr_addr    = aw_held_q ? aw_addr_q : awaddr;
    wr_data    = w_held_q ? w_data_q : wdata;
    wr_strb    = w_held_q ? w_strb_q : wstrb;
    wr_idx     = wr_addr[ADDR_SIZE-1:2];
    wr_inrange = {1'b0, wr_idx} < (IW+1)'(NREGS);

    aw_addr_d  = aw_hs ? awaddr : aw_addr_q;
    w_data_d   = w_hs ? wdata : w_data_q;
    w_strb_d   = w_hs ? wstrb : w_strb_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;

    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs)  w_held_d  = 1'b1;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_inrange ? OKAY : SLVERR;
    end
  end

  // Per-register strobe merge and write enable
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wen[i] = commit && wr_inrange && (wr_idx == IW'(i));

    axi4l_wstrb_merge #(.W(DATA_SIZE), .SW(SW)) u_merge (
      .old_i    (regs_q[i]),
      .new_i    (wr_data),
      .strb_i   (wr_strb),
      .merged_o (merged[i])
    );

    assign regs_d[i] = wen[i] ? merged[i] : regs_q[i];
  end

  // Read channel: lookup from current (pre-write) state, hold until rready
  always_comb begin
    ar_hs      = arvalid && arready;
    rd_idx     = araddr[ADDR_SIZE-1:2];
    rd_inrange = {1'b0, rd_idx} < (IW+1)'(NREGS);
    rd_word    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == IW'(i)) rd_word = regs_q[i];
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_inrange ? rd_word : '0;
      rresp_d  = rd_inrange ? OKAY : SLVERR;
    end
  end

  // State registers; reset drops all in-flight transactions
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4l_regfile_slave.sv
// Self-checking bench for axi4l_regfile_slave against an array-based register model.
module tb_axi4l_regfile_slave;

  localparam int NR = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [9:0]    awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [9:0]    araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [NR*32-1:0] regs_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [NR];

  always #5 ACLK = ~ACLK;

  axi4l_regfile_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out)
  );

  // Model: a write replaces exactly the enabled bytes of the addressed word
  function automatic void model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx < NR)
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] a);
    int idx = int'(a) / 4;
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [9:0] a);
    return (int'(a) / 4 < NR) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== exp_resp(a)) begin
      n_err++; $display("FAIL %s_bresp: bvalid=%b bresp=%b, need bvalid=1 bresp=%b", tag, bvalid, bresp, exp_resp(a));
    end
    n_cmp++;
    if (regs_out !== model_flat()) begin
      n_err++; $display("FAIL %s_regs: regs_out=%h, need %h", tag, regs_out, model_flat());
    end
  endtask

  task automatic do_read(input logic [9:0] a, input string tag);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== model_read(a) || rresp !== exp_resp(a)) begin
      n_err++; $display("FAIL %s_read: rvalid=%b rdata=%h rresp=%b, need 1 %h %b",
                        tag, rvalid, rdata, rresp, model_read(a), exp_resp(a));
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_0000 ||
        rdata !== 32'h0 || regs_out !== '0) begin
      n_err++; $display("FAIL reset: aw/w/ar rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h regs!=0:%b, need 111 0 0 00 00 0 0",
                        awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, |regs_out);
    end
  endtask

  task automatic test_aligned();
    do_write(10'h008, 32'hDEADBEEF, 4'hF, "aligned");
    do_read(10'h008, "aligned");
    n_cmp++;
    if (regs_out[2*32 +: 32] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL aligned_slice: got %h, need deadbeef", regs_out[2*32 +: 32]);
    end
  endtask

  task automatic test_partial();
    do_write(10'h004, 32'h11223344, 4'hF, "partial_init");
    do_write(10'h004, 32'hAABBCCDD, 4'b0101, "partial");
    do_read(10'h004, "partial");
    n_cmp++;
    if (rdata !== 32'h11BB33DD) begin
      n_err++; $display("FAIL partial_value: got %h, need 11bb33dd", rdata);
    end
    do_write(10'h004, 32'hFFFFFFFF, 4'h0, "strb0");
    do_read(10'h004, "strb0");
  endtask

  task automatic test_decoupled();
    wdata = 32'hCAFE0123; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge ACLK); #1;
    wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
        n_err++; $display("FAIL decoupled_wait%0d: wready=%b bvalid=%b, need 0 0", c, wready, bvalid);
      end
      if (c < 3) begin @(posedge ACLK); #1; end
    end
    awaddr = 10'h00F; awvalid = 1'b1;     // low bits ignored -> reg 3
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    model_write(10'h00C, 32'hCAFE0123, 4'hF);
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b1 || regs_out !== model_flat()) begin
      n_err++; $display("FAIL decoupled_commit: bvalid=%b bresp=%b wready=%b reg3=%h, need 1 00 1 cafe0123",
                        bvalid, bresp, wready, regs_out[3*32 +: 32]);
    end
  endtask

  task automatic test_out_of_range();
    do_write(10'h040, 32'h12345678, 4'hF, "oor_w");
    do_read(10'h040, "oor_r");
    do_write(10'h3FC, 32'h9ABCDEF0, 4'hF, "oor_top_w");
    do_read(10'h3FE, "oor_top_r");
    do_read(10'h03C, "last_reg");
  endtask

  task automatic test_backpressure();
    bready = 1'b0;
    awaddr = 10'h050; wdata = 32'h0BAD0BAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge ACLK); #1;
    awaddr = 10'h014; wdata = 32'h55AA55AA; wstrb = 4'hF;
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0 ||
          regs_out !== model_flat()) begin
        n_err++; $display("FAIL bp_hold%0d: bvalid=%b bresp=%b awready=%b wready=%b, need 1 10 0 0",
                          c, bvalid, bresp, awready, wready);
      end
      @(posedge ACLK); #1;
    end
    bready = 1'b1;
    @(posedge ACLK); #1;
    model_write(10'h014, 32'h55AA55AA, 4'hF);
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b1 || regs_out !== model_flat()) begin
      n_err++; $display("FAIL bp_release: bvalid=%b bresp=%b awready=%b reg5=%h, need 1 00 1 55aa55aa",
                        bvalid, bresp, awready, regs_out[5*32 +: 32]);
    end
    @(posedge ACLK); #1;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL bp_bclear: bvalid=%b, need 0", bvalid);
    end
    // Read side: rdata must stay put even if the register changes underneath
    rready = 1'b0; araddr = 10'h014; arvalid = 1'b1;
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    do_write(10'h014, 32'h01010101, 4'hF, "bp_rwrite");
    rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h55AA55AA) begin
        n_err++; $display("FAIL bp_rhold%0d: rvalid=%b arready=%b rdata=%h, need 1 0 55aa55aa",
                          c, rvalid, arready, rdata);
      end
      @(posedge ACLK); #1;
    end
    rready = 1'b1;
    @(posedge ACLK); #1;
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_err++; $display("FAIL bp_rclear: rvalid=%b arready=%b, need 0 1", rvalid, arready);
    end
  endtask

  task automatic test_collision();
    logic [31:0] old_v = model[7];
    awaddr = 10'h01C; wdata = 32'hA5A5F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 10'h01C; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(10'h01C, 32'hA5A5F00D, 4'hF);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1 || regs_out !== model_flat()) begin
      n_err++; $display("FAIL collision: rdata=%h reg7=%h, need old %h new a5a5f00d",
                        rdata, regs_out[7*32 +: 32], old_v);
    end
  endtask

  task automatic test_back_to_back();
    bready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      awaddr = 10'(k * 4 + 32); wdata = $urandom; wstrb = 4'(($urandom % 15) + 1);
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge ACLK); #1;
      model_write(awaddr, wdata, wstrb);
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b1 || wready !== 1'b1 ||
          regs_out !== model_flat()) begin
        n_err++; $display("FAIL b2b%0d: bvalid=%b bresp=%b awready=%b wready=%b", k, bvalid, bresp, awready, wready);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [9:0] a = 10'($urandom_range(0, 95));
      if ($urandom % 2) do_write(a, $urandom, 4'($urandom), "rand_w");
      else              do_read(a, "rand_r");
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid();
    bready = 1'b0;
    do_write(10'h000, 32'h77777777, 4'hF, "rst_setup");
    bready = 1'b0;
    awaddr = 10'h004; awvalid = 1'b1;
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    n_cmp++;
    if (awready !== 1'b0 || bvalid !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: awready=%b bvalid=%b, need 0 1", awready, bvalid);
    end
    #2 ARESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    test_reset();
    @(negedge ACLK); ARESETn = 1'b1;
    wvalid = 1'b1; wdata = 32'h3; wstrb = 4'hF; bready = 1'b1;
    @(posedge ACLK); #1;
    wvalid = 1'b0;
    @(posedge ACLK); #1;
    n_cmp++;
    if (bvalid !== 1'b0 || regs_out !== '0) begin
      n_err++; $display("FAIL rst_post: bvalid=%b regs_nonzero=%b, need 0 0", bvalid, |regs_out);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1;
    test_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESETn = 1'b1;
    @(posedge ACLK); #1;
    test_aligned();
    test_partial();
    test_decoupled();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need completion");
    $fatal(1, "timeout");
  end

endmodule
